blood_display_ctrl: RTL and testbench

- Owns both fighters' health values and drives the shared 64x64, 12-bit blood-digit sprite ROM bank (digits 0-9) for the on-screen health readouts.
- Per frame, converts each health value to tens/ones digits with a sequential subtractor, then commits both readouts together at one frame boundary.
- Per pixel, decodes x/y into a digit select plus ROM row/col, aligns the ROM's 1-cycle read latency and produces a registered overlay pixel for the VGA colour mux.

---
 rtl/blood_display_ctrl.sv | 170 +++++++++++++++++
 tb/tb_blood_display_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/blood_display_ctrl.sv
// Health registers, per-frame BCD conversion and pixel overlay for the two fighters' health readouts.
// Digit sprites come from an external 64x64 ROM bank with one cycle of read latency.
module blood_display_ctrl #(
   parameter int MAX_HP = 99,
   parameter int P1_X0  = 32,
   parameter int P2_X0  = 480,
   parameter int BAR_Y0 = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_start,
   input  logic        video_on,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        game_restart,
   input  logic        dmg_valid_p1,
   input  logic [6:0]  dmg_amt_p1,
   input  logic        dmg_valid_p2,
   input  logic [6:0]  dmg_amt_p2,
   output logic [3:0]  rom_digit,
   output logic [5:0]  rom_row,
   output logic [5:0]  rom_col,
   input  logic [11:0] rom_data,
   output logic [11:0] pix_rgb,
   output logic        pix_hit,
   output logic        ko_p1,
   output logic        ko_p2,
   output logic        conv_busy
);

   localparam logic [6:0] HP_INIT = 7'(MAX_HP);
   localparam logic [3:0] INIT_T  = 4'(MAX_HP / 10);
   localparam logic [3:0] INIT_O  = 4'(MAX_HP % 10);
   localparam logic [9:0] P1T_L   = 10'(P1_X0);
   localparam logic [9:0] P1O_L   = 10'(P1_X0 + 64);
   localparam logic [9:0] P1_END  = 10'(P1_X0 + 128);
   localparam logic [9:0] P2T_L   = 10'(P2_X0);
   localparam logic [9:0] P2O_L   = 10'(P2_X0 + 64);
   localparam logic [9:0] P2_END  = 10'(P2_X0 + 128);
   localparam logic [9:0] Y_TOP   = 10'(BAR_Y0);
   localparam logic [9:0] Y_END   = 10'(BAR_Y0 + 64);

   logic       dmg_valid [2];
   logic [6:0] dmg_amt   [2];

   assign dmg_valid[0] = dmg_valid_p1;
   assign dmg_valid[1] = dmg_valid_p2;
   assign dmg_amt[0]   = dmg_amt_p1;
   assign dmg_amt[1]   = dmg_amt_p2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_hp
         logic [6:0] hp_reg;
         logic       ko_reg;
         // Restart wins over a same-cycle hit; damage saturates at zero.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               hp_reg <= HP_INIT;
               ko_reg <= 1'b0;
            end else begin
               if (game_restart)
                  hp_reg <= HP_INIT;
               else if (dmg_valid[gi])
                  hp_reg <= (dmg_amt[gi] >= hp_reg) ? 7'd0 : hp_reg - dmg_amt[gi];
               ko_reg <= (hp_reg == 7'd0);
            end
         end
      end
   endgenerate

   assign ko_p1 = g_hp[0].ko_reg;
   assign ko_p2 = g_hp[1].ko_reg;

   typedef enum logic [1:0] {IDLE, DIV1, DIV2, COMMIT} state_t;
   state_t     state;
   logic [6:0] w1, w2;
   logic [3:0] t1, t2, ones1, ones2;
   logic [3:0] disp_t1, disp_o1, disp_t2, disp_o2;

   // Displayed digits only move in COMMIT so a frame never shows a half-updated readout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         w1        <= '0;
         w2        <= '0;
         t1        <= '0;
         t2        <= '0;
         ones1     <= '0;
         ones2     <= '0;
         disp_t1   <= INIT_T;
         disp_o1   <= INIT_O;
         disp_t2   <= INIT_T;
         disp_o2   <= INIT_O;
         conv_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: if (frame_start) begin
               w1        <= g_hp[0].hp_reg;
               w2        <= g_hp[1].hp_reg;
               t1        <= '0;
               t2        <= '0;
               conv_busy <= 1'b1;
               state     <= DIV1;
            end
            DIV1: if (w1 >= 7'd10) begin
               w1 <= w1 - 7'd10;
               t1 <= t1 + 4'd1;
            end else begin
               ones1 <= w1[3:0];
               state <= DIV2;
            end
            DIV2: if (w2 >= 7'd10) begin
               w2 <= w2 - 7'd10;
               t2 <= t2 + 4'd1;
            end else begin
               ones2 <= w2[3:0];
               state <= COMMIT;
            end
            COMMIT: begin
               disp_t1   <= t1;
               disp_o1   <= ones1;
               disp_t2   <= t2;
               disp_o2   <= ones2;
               conv_busy <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic in_y, hit, hit_d;

   assign in_y = (y >= Y_TOP) && (y < Y_END);

   always_comb begin
      rom_digit = 4'd0;
      rom_row   = 6'd0;
      rom_col   = 6'd0;
      hit       = 1'b0;
      if (video_on && in_y) begin
         if (x >= P1T_L && x < P1O_L) begin
            hit = 1'b1; rom_digit = disp_t1; rom_col = x[5:0] - P1T_L[5:0];
         end else if (x >= P1O_L && x < P1_END) begin
            hit = 1'b1; rom_digit = disp_o1; rom_col = x[5:0] - P1O_L[5:0];
         end else if (x >= P2T_L && x < P2O_L) begin
            hit = 1'b1; rom_digit = disp_t2; rom_col = x[5:0] - P2T_L[5:0];
         end else if (x >= P2O_L && x < P2_END) begin
            hit = 1'b1; rom_digit = disp_o2; rom_col = x[5:0] - P2O_L[5:0];
         end
         if (hit)
            rom_row = y[5:0] - Y_TOP[5:0];
      end
   end

   // hit_d lines up with rom_data; black ROM texels are treated as transparent.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_d   <= 1'b0;
         pix_hit <= 1'b0;
         pix_rgb <= 12'h000;
      end else begin
         hit_d   <= hit;
         pix_hit <= hit_d && (rom_data != 12'h000);
         pix_rgb <= (hit_d && (rom_data != 12'h000)) ? rom_data : 12'h000;
      end
   end

endmodule

// File: tb/tb_blood_display_ctrl.sv
// Directed bench for blood_display_ctrl: health model, conversion timing, digit probes
// and a scoreboard for the two-stage pixel path against a behavioural sprite ROM.
module tb_blood_display_ctrl;

   localparam int MAX_HP = 99;
   localparam int P1_X0  = 32;
   localparam int P2_X0  = 480;
   localparam int BAR_Y0 = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        frame_start = 1'b0;
   logic        video_on = 1'b0;
   logic [9:0]  x = '0;
   logic [9:0]  y = '0;
   logic        game_restart = 1'b0;
   logic        dmg_valid_p1 = 1'b0;
   logic [6:0]  dmg_amt_p1 = '0;
   logic        dmg_valid_p2 = 1'b0;
   logic [6:0]  dmg_amt_p2 = '0;
   logic [3:0]  rom_digit;
   logic [5:0]  rom_row;
   logic [5:0]  rom_col;
   logic [11:0] rom_data = '0;
   logic [11:0] pix_rgb;
   logic        pix_hit;
   logic        ko_p1, ko_p2, conv_busy;

   int errors = 0;
   int checks = 0;
   int m_hp1 = MAX_HP, m_hp2 = MAX_HP;
   int d_t1 = 9, d_o1 = 9, d_t2 = 9, d_o2 = 9;
   logic [12:0] sb_q[$];

   blood_display_ctrl #(.MAX_HP(MAX_HP), .P1_X0(P1_X0), .P2_X0(P2_X0), .BAR_Y0(BAR_Y0)) dut (
      .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .video_on(video_on),
      .x(x), .y(y), .game_restart(game_restart),
      .dmg_valid_p1(dmg_valid_p1), .dmg_amt_p1(dmg_amt_p1),
      .dmg_valid_p2(dmg_valid_p2), .dmg_amt_p2(dmg_amt_p2),
      .rom_digit(rom_digit), .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
      .pix_rgb(pix_rgb), .pix_hit(pix_hit), .ko_p1(ko_p1), .ko_p2(ko_p2), .conv_busy(conv_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rom_fn(input logic [3:0] d, input logic [5:0] r, input logic [5:0] c);
      if (d == 4'd5 && r == 6'd10 && c == 6'd20) return 12'hE00;
      if (r == 6'd11) return 12'h000;
      return {d, r, 2'b01};
   endfunction

   always @(posedge clk) rom_data <= rom_fn(rom_digit, rom_row, rom_col);

   function automatic int hit_hp(input int hp, input int amt);
      return (amt >= hp) ? 0 : hp - amt;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic probe_all;
      int wl[4];
      int wd[4];
      wl = '{P1_X0, P1_X0 + 64, P2_X0, P2_X0 + 64};
      wd = '{d_t1, d_o1, d_t2, d_o2};
      video_on = 1'b1;
      for (int i = 0; i < 4; i++) begin
         x = 10'(wl[i] + 3);
         y = 10'(BAR_Y0 + 2);
         #1;
         chk($sformatf("digit_w%0d", i), rom_digit, wd[i]);
         chk($sformatf("row_w%0d", i), rom_row, 2);
         chk($sformatf("col_w%0d", i), rom_col, 3);
      end
      $display("probe digits %0d%0d %0d%0d", rom_digit, d_o1, d_t2, d_o2);
   endtask

   task automatic damage(input bit v1, input int a1, input bit v2, input int a2, input bit rst);
      dmg_valid_p1 = v1; dmg_amt_p1 = 7'(a1);
      dmg_valid_p2 = v2; dmg_amt_p2 = 7'(a2);
      game_restart = rst;
      if (rst) begin
         m_hp1 = MAX_HP; m_hp2 = MAX_HP;
      end else begin
         if (v1) m_hp1 = hit_hp(m_hp1, a1);
         if (v2) m_hp2 = hit_hp(m_hp2, a2);
      end
      tick;
      dmg_valid_p1 = 1'b0; dmg_valid_p2 = 1'b0; game_restart = 1'b0;
      $display("damage p1=%0d/%0d p2=%0d/%0d restart=%0d -> model hp %0d %0d", v1, a1, v2, a2, rst, m_hp1, m_hp2);
   endtask

   // poke: re-pulse frame_start and damage P2 while the conversion is running
   task automatic run_conv(input bit poke);
      int s1, s2, n;
      s1 = m_hp1; s2 = m_hp2;
      video_on = 1'b1; x = 10'(P1_X0 + 1); y = 10'(BAR_Y0 + 1);
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      n = 1;
      chk("busy_rise", conv_busy, 1);
      while (conv_busy && n < 60) begin
         chk("no_tear", rom_digit, d_t1);
         if (poke && n == 3) begin
            frame_start = 1'b1;
            dmg_valid_p2 = 1'b1; dmg_amt_p2 = 7'd1;
            m_hp2 = hit_hp(m_hp2, 1);
         end
         tick;
         n++;
         frame_start = 1'b0; dmg_valid_p2 = 1'b0;
      end
      chk("conv_done", conv_busy, 0);
      chk("conv_cycles", n, s1 / 10 + s2 / 10 + 4);
      $display("conversion hp %0d %0d took %0d cycles", s1, s2, n);
      d_t1 = s1 / 10; d_o1 = s1 % 10; d_t2 = s2 / 10; d_o2 = s2 % 10;
      probe_all();
      tick;
      chk("stay_idle", conv_busy, 0);
   endtask

   task automatic pix(input string tag, input int xx, input int yy, input bit vo,
                      input logic exp_hit, input logic [11:0] exp_rgb);
      logic [12:0] e;
      x = 10'(xx); y = 10'(yy); video_on = vo;
      sb_q.push_back({exp_hit, exp_rgb});
      tick;
      x = '0; y = '0;
      tick;
      e = sb_q.pop_front();
      chk({tag, "_hit"}, pix_hit, e[12]);
      chk({tag, "_rgb"}, pix_rgb, e[11:0]);
      $display("pixel %s x=%0d y=%0d vo=%0d hit=%0d rgb=%03h", tag, xx, yy, vo, pix_hit, pix_rgb);
   endtask

   initial begin
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      tick; tick;
      chk("rst_pix_hit", pix_hit, 0);
      chk("rst_pix_rgb", pix_rgb, 0);
      chk("rst_ko_p1", ko_p1, 0);
      chk("rst_ko_p2", ko_p2, 0);
      chk("rst_busy", conv_busy, 0);
      reset_n = 1'b1;
      tick;
      probe_all();

      // P1 knocked out, then hit again at zero
      damage(1, 40, 0, 0, 0);
      damage(1, 70, 0, 0, 0);
      chk("ko_p1_lag", ko_p1, 0);
      tick;
      chk("ko_p1_set", ko_p1, 1);
      chk("ko_p2_clr", ko_p2, 0);
      damage(1, 5, 0, 0, 0);
      run_conv(0);

      damage(0, 0, 0, 0, 1);
      chk("ko_p1_after_restart", ko_p1, 1);
      tick;
      chk("ko_p1_cleared", ko_p1, 0);

      // simultaneous damage: hp1=57, hp2=3
      damage(1, 42, 1, 96, 0);
      tick;
      chk("ko_p2_hp3", ko_p2, 0);
      run_conv(1);

      pix("sprite", P1_X0 + 20, BAR_Y0 + 10, 1, 1'b1, 12'hE00);
      x = 10'(P1_X0 + 20); y = 10'(BAR_Y0 + 10); video_on = 1'b1;
      #1;
      chk("addr_digit", rom_digit, 5);
      chk("addr_row", rom_row, 10);
      chk("addr_col", rom_col, 20);
      pix("transparent", P1_X0 + 20, BAR_Y0 + 11, 1, 1'b0, 12'h000);
      pix("blanked", P1_X0 + 20, BAR_Y0 + 10, 0, 1'b0, 12'h000);
      pix("p2_ones", P2_X0 + 64 + 5, BAR_Y0 + 2, 1, 1'b1, 12'h309);
      pix("outside", 300, BAR_Y0 + 2, 1, 1'b0, 12'h000);
      pix("below", P1_X0 + 5, BAR_Y0 + 64, 1, 1'b0, 12'h000);
      x = 10'd300; y = 10'(BAR_Y0 + 2); video_on = 1'b1;
      #1;
      chk("outside_digit", rom_digit, 0);
      chk("outside_col", rom_col, 0);

      // damage taken mid-conversion shows up on this frame
      run_conv(0);

      // reset while the divider is running
      video_on = 1'b1; x = 10'(P1_X0 + 1); y = 10'(BAR_Y0 + 1);
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      tick; tick;
      chk("mid_busy", conv_busy, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", conv_busy, 0);
      m_hp1 = MAX_HP; m_hp2 = MAX_HP;
      d_t1 = 9; d_o1 = 9; d_t2 = 9; d_o2 = 9;
      probe_all();
      tick;
      reset_n = 1'b1;
      tick;
      chk("post_rst_busy", conv_busy, 0);

      damage(1, 10, 0, 0, 0);
      // restart overrides damage in the same cycle
      dmg_valid_p1 = 1'b1; dmg_amt_p1 = 7'd5;
      dmg_valid_p2 = 1'b1; dmg_amt_p2 = 7'd50;
      game_restart = 1'b1;
      m_hp1 = MAX_HP; m_hp2 = MAX_HP;
      tick;
      dmg_valid_p1 = 1'b0; dmg_valid_p2 = 1'b0; game_restart = 1'b0;
      $display("restart with damage -> model hp %0d %0d", m_hp1, m_hp2);
      run_conv(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
